// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants used by the program loader and its helpers.
package cpu_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        CHK,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Shifts big-endian bytes into a 32-bit word and pulses o_wordValid the cycle after the 4th byte.
module word_assembler
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [1:0]        o_byteIdx,
    output logic [WORD_W-1:0] o_word,
    output logic              o_wordValid
);

    logic [WORD_W-BYTE_W-1:0] r_shift;
    logic [1:0]               r_byteIdx;
    logic [WORD_W-1:0]        r_word;
    logic                     r_wordValid;

    // The finished word is latched separately so it stays put while the next word shifts in.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_shift     <= '0;
            r_byteIdx   <= '0;
            r_word      <= '0;
            r_wordValid <= 1'b0;
        end else begin
            r_wordValid <= 1'b0;
            if (i_clear) begin
                r_shift   <= '0;
                r_byteIdx <= '0;
            end else if (i_valid) begin
                r_shift   <= {r_shift[WORD_W-2*BYTE_W-1:0], i_byte};
                r_byteIdx <= r_byteIdx + 2'd1;
                if (r_byteIdx == 2'd3) begin
                    r_word      <= {r_shift, i_byte};
                    r_wordValid <= 1'b1;
                end
            end
        end
    end

    assign o_byteIdx   = r_byteIdx;
    assign o_word      = r_word;
    assign o_wordValid = r_wordValid;

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a framed byte stream into IMem writes and releases the CPU on a verified load.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam int DEPTH = 1 << ADDR_W;

    loader_state_t     r_state;
    loader_state_t     w_nextState;
    logic [15:0]       r_count;
    logic [15:0]       r_wordIdx;
    logic [BYTE_W-1:0] r_chk;
    logic [ADDR_W-1:0] r_addr;
    logic              r_cpuReset;
    logic              r_done;
    logic              r_error;

    logic              w_inReady;
    logic              w_xfer;
    logic              w_dataXfer;
    logic              w_lastByte;
    logic [15:0]       w_nFull;
    logic [1:0]        w_byteIdx;
    logic [WORD_W-1:0] w_word;
    logic              w_wordValid;

    assign w_inReady  = (r_state == HDR_HI) || (r_state == HDR_LO) ||
                        (r_state == DATA)   || (r_state == CHK);
    // A start pulse wins over a byte offered in the same cycle; that byte is dropped.
    assign w_xfer     = in_valid && w_inReady && !start;
    assign w_dataXfer = w_xfer && (r_state == DATA);
    assign w_lastByte = w_dataXfer && (w_byteIdx == 2'd3);
    assign w_nFull    = {r_count[15:8], in_byte};

    word_assembler u_asm (
        .clock       (clock),
        .reset       (reset),
        .i_clear     (start),
        .i_valid     (w_dataXfer),
        .i_byte      (in_byte),
        .o_byteIdx   (w_byteIdx),
        .o_word      (w_word),
        .o_wordValid (w_wordValid)
    );

    always_comb begin
        w_nextState = r_state;
        if (start) begin
            w_nextState = HDR_HI;
        end else begin
            case (r_state)
                HDR_HI: if (w_xfer) w_nextState = HDR_LO;
                HDR_LO: begin
                    if (w_xfer) begin
                        if (w_nFull == 16'd0)
                            w_nextState = CHK;
                        else if ({1'b0, w_nFull} > 17'(DEPTH))
                            w_nextState = ERR;
                        else
                            w_nextState = DATA;
                    end
                end
                DATA: if (w_lastByte && (r_wordIdx + 16'd1 == r_count)) w_nextState = CHK;
                CHK:  if (w_xfer) w_nextState = (in_byte == r_chk) ? DONE : ERR;
                default: w_nextState = r_state;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cpuReset <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_cpuReset <= (w_nextState == DONE);
            r_done     <= (w_nextState == DONE);
            r_error    <= (w_nextState == ERR);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count   <= '0;
            r_wordIdx <= '0;
            r_chk     <= '0;
            r_addr    <= '0;
        end else if (start) begin
            r_count   <= '0;
            r_wordIdx <= '0;
            r_chk     <= '0;
        end else begin
            if (w_xfer && (r_state == HDR_HI)) r_count[15:8] <= in_byte;
            if (w_xfer && (r_state == HDR_LO)) r_count[7:0]  <= in_byte;
            if (w_xfer && (r_state != CHK))    r_chk         <= r_chk ^ in_byte;
            if (w_lastByte) begin
                r_addr    <= r_wordIdx[ADDR_W-1:0];
                r_wordIdx <= r_wordIdx + 16'd1;
            end
        end
    end

    assign in_ready   = w_inReady;
    assign imem_we    = w_wordValid;
    assign imem_addr  = r_addr;
    assign imem_wdata = w_word;
    assign cpu_reset  = r_cpuReset;
    assign done       = r_done;
    assign error      = r_error;

endmodule
